// File: rtl/acoustics_pkg.sv
// Shared definitions for the acoustics front end: capture sequencer state
// encoding and default SIPO/logger sizing.
package acoustics_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_DATA_BITS    = 16;
    localparam int DEF_CONV_CYCLES  = 8;
    localparam int DEF_NUM_SAMPLES  = 1024;
    localparam int DEF_SAMPLE_CNT_W = 10;

    localparam int PHASE_CNT_W = 8;
    localparam int BIT_CNT_W   = 5;

endpackage

// File: rtl/phase_counter.sv
// Up-counter with synchronous clear (priority over enable) and a
// terminal-count flag raised while the count equals TERMINAL.
module phase_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/sipo_capture_sequencer.sv
// Moore FSM sequencing one capture window: per sample it converts, shifts
// DATA_BITS serial bits into the SIPO register and latches the word.
module sipo_capture_sequencer
    import acoustics_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CONV_CYCLES  = DEF_CONV_CYCLES,
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
    parameter int SAMPLE_CNT_W = DEF_SAMPLE_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    control_signal,
    input  logic                    abort,
    output logic                    adc_convst,
    output logic                    adc_cs_n,
    output logic                    sipo_shift_en,
    output logic                    sipo_latch,
    output logic                    data_logging,
    output logic                    data_ready,
    output logic                    capture_done,
    output logic [SAMPLE_CNT_W-1:0] sample_count,
    output logic [4:0]              bit_count
);

    // One spare bit so the count can reach NUM_SAMPLES = 2^SAMPLE_CNT_W.
    localparam int SCNT_W = SAMPLE_CNT_W + 1;

    state_t state_q, state_d;

    logic                   start, abort_act;
    logic                   phase_tc, bit_tc, samp_tc;
    logic [PHASE_CNT_W-1:0] phase_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [SCNT_W-1:0]      samp_cnt;
    logic                   unused_ok;

    function automatic logic [SAMPLE_CNT_W-1:0] sat_count(input logic [SCNT_W-1:0] c);
        if (c[SCNT_W-1]) begin
            return '1;
        end
        return c[SAMPLE_CNT_W-1:0];
    endfunction

    assign start     = (state_q == ST_IDLE) && control_signal && !abort;
    assign abort_act = abort && ((state_q == ST_CONVERT) || (state_q == ST_SHIFT) ||
                                 (state_q == ST_LATCH));

    phase_counter #(.WIDTH(PHASE_CNT_W), .TERMINAL(CONV_CYCLES - 1)) u_phase (
        .clk    (clk),
        .reset  (reset),
        .clr_i  ((state_q != ST_CONVERT) || phase_tc || abort_act),
        .en_i   (state_q == ST_CONVERT),
        .count_o(phase_cnt),
        .tc_o   (phase_tc)
    );

    phase_counter #(.WIDTH(BIT_CNT_W), .TERMINAL(DATA_BITS - 1)) u_bit (
        .clk    (clk),
        .reset  (reset),
        .clr_i  ((state_q == ST_IDLE) || (state_q == ST_LATCH) || abort_act),
        .en_i   (state_q == ST_SHIFT),
        .count_o(bit_cnt),
        .tc_o   (bit_tc)
    );

    // An abort during LATCH drops the sample, so the count must not advance.
    phase_counter #(.WIDTH(SCNT_W), .TERMINAL(NUM_SAMPLES - 1)) u_sample (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start),
        .en_i   ((state_q == ST_LATCH) && !abort),
        .count_o(samp_cnt),
        .tc_o   (samp_tc)
    );

    assign unused_ok = ^phase_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        adc_convst    = 1'b0;
        adc_cs_n      = 1'b1;
        sipo_shift_en = 1'b0;
        sipo_latch    = 1'b0;
        data_logging  = 1'b0;
        data_ready    = 1'b0;
        capture_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                adc_convst   = 1'b1;
                data_logging = 1'b1;
                if (abort)         state_d = ST_IDLE;
                else if (phase_tc) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                adc_cs_n      = 1'b0;
                sipo_shift_en = 1'b1;
                data_logging  = 1'b1;
                if (abort)       state_d = ST_IDLE;
                else if (bit_tc) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                sipo_latch   = 1'b1;
                data_ready   = 1'b1;
                data_logging = 1'b1;
                if (abort)        state_d = ST_IDLE;
                else if (samp_tc) state_d = ST_DONE;
                else              state_d = ST_CONVERT;
            end
            ST_DONE: begin
                capture_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sample_count = sat_count(samp_cnt);
    assign bit_count    = bit_cnt;

endmodule

// File: tb/tb_sipo_capture_sequencer.sv
// Directed bench for sipo_capture_sequencer with DATA_BITS=16, CONV_CYCLES=8,
// NUM_SAMPLES=4: a per-cycle vector table plus abort/reset/start corner cases.
module tb_sipo_capture_sequencer;

    localparam int DATA_BITS    = 16;
    localparam int CONV_CYCLES  = 8;
    localparam int NUM_SAMPLES  = 4;
    localparam int SAMPLE_CNT_W = 10;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    control_signal = 1'b0;
    logic                    abort = 1'b0;
    logic                    adc_convst, adc_cs_n, sipo_shift_en, sipo_latch;
    logic                    data_logging, data_ready, capture_done;
    logic [SAMPLE_CNT_W-1:0] sample_count;
    logic [4:0]              bit_count;

    int total = 0;
    int bad   = 0;

    sipo_capture_sequencer #(
        .DATA_BITS   (DATA_BITS),
        .CONV_CYCLES (CONV_CYCLES),
        .NUM_SAMPLES (NUM_SAMPLES),
        .SAMPLE_CNT_W(SAMPLE_CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .control_signal(control_signal),
        .abort         (abort),
        .adc_convst    (adc_convst),
        .adc_cs_n      (adc_cs_n),
        .sipo_shift_en (sipo_shift_en),
        .sipo_latch    (sipo_latch),
        .data_logging  (data_logging),
        .data_ready    (data_ready),
        .capture_done  (capture_done),
        .sample_count  (sample_count),
        .bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    // rel is the cycle offset from the start pulse; sc/bc of -1 mean don't care.
    typedef struct {
        int rel;
        int convst, cs_n, shift, latch, logging, ready, done, sc, bc;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl[NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t v);
        chk({name, "_convst"}, int'(adc_convst), v.convst);
        chk({name, "_cs_n"}, int'(adc_cs_n), v.cs_n);
        chk({name, "_shift"}, int'(sipo_shift_en), v.shift);
        chk({name, "_latch"}, int'(sipo_latch), v.latch);
        chk({name, "_logging"}, int'(data_logging), v.logging);
        chk({name, "_ready"}, int'(data_ready), v.ready);
        chk({name, "_done"}, int'(capture_done), v.done);
        if (v.sc >= 0) chk({name, "_scount"}, int'(sample_count), v.sc);
        if (v.bc >= 0) chk({name, "_bcount"}, int'(bit_count), v.bc);
    endtask

    task automatic run_window(input bit extra, input string tag);
        int  idx = 0;
        int  rdy_n = 0, done_n = 0, log_n = 0, last_rdy = -1, sh_n = 0, csl_n = 0;
        bit  after_latch = 1'b0;
        for (int rel = 0; rel <= 106; rel++) begin
            control_signal = (rel == 0) || (extra && (rel == 4 || rel == 12));
            if (idx < NV && tbl[idx].rel == rel) begin
                chk_vec($sformatf("%s_r%0d", tag, rel), tbl[idx]);
                idx++;
            end
            if (after_latch) begin
                chk({tag, "_bit_clr"}, int'(bit_count), 0);
                after_latch = 1'b0;
            end
            if (sipo_shift_en) begin
                chk({tag, "_bit_idx"}, int'(bit_count), sh_n);
                sh_n++;
            end
            if (!adc_cs_n) csl_n++;
            if (data_logging) log_n++;
            if (capture_done) begin
                done_n++;
                chk({tag, "_done_rel"}, rel, 101);
            end
            if (data_ready) begin
                rdy_n++;
                if (last_rdy >= 0) chk({tag, "_ready_gap"}, rel - last_rdy, 25);
                last_rdy = rel;
            end
            if (sipo_latch) begin
                chk({tag, "_shift_cycles"}, sh_n, DATA_BITS);
                chk({tag, "_csn_low_cycles"}, csl_n, DATA_BITS);
                sh_n = 0;
                csl_n = 0;
                after_latch = 1'b1;
            end
            step();
        end
        control_signal = 1'b0;
        chk({tag, "_ready_count"}, rdy_n, NUM_SAMPLES);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_logging_cycles"}, log_n, 100);
        chk({tag, "_rows_seen"}, idx, NV);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        int   rdy_n, done_n, log_n;

        tbl[0]  = '{0,   0, 1, 0, 0, 0, 0, 0, -1, 0};
        tbl[1]  = '{1,   1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{8,   1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{9,   0, 0, 1, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{15,  0, 0, 1, 0, 1, 0, 0, 0, 6};
        tbl[5]  = '{24,  0, 0, 1, 0, 1, 0, 0, 0, 15};
        tbl[6]  = '{25,  0, 1, 0, 1, 1, 1, 0, 0, -1};
        tbl[7]  = '{26,  1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[8]  = '{50,  0, 1, 0, 1, 1, 1, 0, 1, -1};
        tbl[9]  = '{75,  0, 1, 0, 1, 1, 1, 0, 2, -1};
        tbl[10] = '{100, 0, 1, 0, 1, 1, 1, 0, 3, -1};
        tbl[11] = '{101, 0, 1, 0, 0, 0, 0, 1, 4, 0};
        tbl[12] = '{102, 0, 1, 0, 0, 0, 0, 0, 4, 0};

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        chk_vec("reset", idle);
        repeat (6) step();

        // Full window, then the same with ignored start pulses in CONVERT/SHIFT
        run_window(1'b0, "s1");
        repeat (3) step();
        run_window(1'b1, "s4");
        repeat (3) step();

        // Abort on the 7th shift cycle of the second sample
        for (int rel = 0; rel < 40; rel++) begin
            control_signal = (rel == 0);
            step();
        end
        control_signal = 1'b0;
        chk("ab_in_shift", int'(sipo_shift_en), 1);
        chk("ab_bit_at_abort", int'(bit_count), 6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        idle = '{0, 0, 1, 0, 0, 0, 0, 0, 1, -1};
        chk_vec("ab_idle", idle);
        rdy_n = 0; done_n = 0; log_n = 0;
        for (int i = 0; i < 120; i++) begin
            if (data_ready) rdy_n++;
            if (capture_done) done_n++;
            if (data_logging) log_n++;
            step();
        end
        chk("ab_ready_after", rdy_n, 0);
        chk("ab_done_after", done_n, 0);
        chk("ab_logging_after", log_n, 0);
        chk("ab_scount_hold", int'(sample_count), 1);

        // Reset during LATCH of the first sample
        for (int rel = 0; rel < 25; rel++) begin
            control_signal = (rel == 0);
            step();
        end
        control_signal = 1'b0;
        chk("rst_in_latch", int'(sipo_latch), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        chk_vec("rst_latch", idle);
        repeat (3) step();
        run_window(1'b0, "s5");
        repeat (3) step();

        // Start and abort together in IDLE
        control_signal = 1'b1;
        abort = 1'b1;
        step();
        control_signal = 1'b0;
        abort = 1'b0;
        idle = '{0, 0, 1, 0, 0, 0, 0, 0, -1, -1};
        chk_vec("both_idle", idle);
        repeat (5) step();
        chk("both_later_logging", int'(data_logging), 0);
        chk("both_later_convst", int'(adc_convst), 0);
        run_window(1'b0, "s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_capture_sequencer.md
Name: sipo_capture_sequencer

Overview:
Sequences one hydrophone ADC sample capture window for the acoustics front end.
- On a start pulse from the button handler, it repeatedly commands an ADC conversion, clocks DATA_BITS serial bits into the SIPO shift register, then latches the parallel word, for NUM_SAMPLES samples.
- It drives the SIPO register's shift and latch enables and the ADC strobes.
- It reports logging status, per-sample ready strobes and end-of-window to downstream buffering.

Parameters:
DATA_BITS, 16, serial bits per sample; shift phase length in cycles (2..31).
CONV_CYCLES, 8, cycles convst is held high per sample (1..255).
NUM_SAMPLES, 1024, samples per capture window (2..2^SAMPLE_CNT_W).
SAMPLE_CNT_W, 10, width of sample_count.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
control_signal  input  1  start request, one-cycle pulse from button handler.
abort  input  1  terminate capture immediately.
adc_convst  output  1  ADC conversion start, high during CONVERT.
adc_cs_n  output  1  ADC chip select, active low, low only during SHIFT.
sipo_shift_en  output  1  SIPO shift enable, high during SHIFT.
sipo_latch  output  1  SIPO parallel-latch strobe, one cycle per sample.
data_logging  output  1  high while a capture window is active.
data_ready  output  1  one-cycle strobe, same cycle as sipo_latch.
capture_done  output  1  one-cycle strobe at normal end of window.
sample_count  output  SAMPLE_CNT_W  samples latched so far in current window.
bit_count  output  5  bits shifted so far in current sample.

Behaviour:
- One clock, synchronous active-high reset. Moore FSM: all strobe outputs decode from the registered state only.
- Reset values:
  - state=IDLE.
  - adc_convst=0, adc_cs_n=1, sipo_shift_en=0, sipo_latch=0.
  - data_logging=0, data_ready=0, capture_done=0.
  - sample_count=0, bit_count=0.
- States: IDLE, CONVERT, SHIFT, LATCH, DONE.
- IDLE:
  - all strobes low, adc_cs_n=1.
  - control_signal=1 sampled -> CONVERT next cycle; clear sample_count, bit_count and phase counter.
- CONVERT:
  - adc_convst=1, data_logging=1.
  - Phase counter runs 0..CONV_CYCLES-1; on the last count -> SHIFT, clear phase counter.
- SHIFT:
  - adc_cs_n=0, sipo_shift_en=1, data_logging=1.
  - bit_count increments each cycle; on bit_count=DATA_BITS-1 -> LATCH.
  - Exactly DATA_BITS shift cycles per sample.
- LATCH:
  - Active for one cycle: sipo_latch=1, data_ready=1, data_logging=1.
  - sample_count increments; bit_count clears.
  - If sample_count was NUM_SAMPLES-1 -> DONE, else -> CONVERT.
- DONE:
  - Active for one cycle: capture_done=1, data_logging=0.
  - Transitions to IDLE. sample_count holds the final value NUM_SAMPLES until the next start.
- Per-sample period is CONV_CYCLES+DATA_BITS+1 cycles. data_logging stays high for NUM_SAMPLES*(CONV_CYCLES+DATA_BITS+1) consecutive cycles.
- control_signal outside IDLE is ignored; there is no restart mid-window.
- abort:
  - Priority over all transitions except reset.
  - From any active state -> IDLE next cycle; no capture_done, no data_ready.
  - Partial shift is discarded; sample_count holds its value. abort in IDLE/DONE has no effect.
- control_signal and abort high together in IDLE: abort wins, stay IDLE.
- Reset mid-operation: returns to the reset values on the next edge, regardless of state.
- Counters never wrap:
  - sample_count max is NUM_SAMPLES, requiring width SAMPLE_CNT_W+1 internally if NUM_SAMPLES=2^SAMPLE_CNT_W. The output saturates at all-ones in that case.
  - The phase counter is 8 bits.
- Illegal state encodings -> IDLE.

Decomposition:
- Shared package acoustics_pkg holds:
  - state encoding constants (IDLE=0, CONVERT=1, SHIFT=2, LATCH=3, DONE=4);
  - default DATA_BITS/CONV_CYCLES/NUM_SAMPLES constants used by the SIPO datapath and logger.
- One sub-module, phase_counter: width-parameterised, synchronous clear and enable, terminal-count output. It is instantiated for the phase, bit and sample counters.

Test Plan:
1. Use DATA_BITS=16, CONV_CYCLES=8, NUM_SAMPLES=4.
   - Stimulus: reset 3 cycles, then control_signal pulse at cycle 10.
   - Response: CONVERT from cycle 11 with convst high 8 cycles, then shift_en high 16 cycles, then latch/data_ready at cycle 35.
   - 4 data_ready strobes spaced 25 cycles apart; capture_done once at cycle 111; data_logging high exactly 100 cycles.
2. Count shift_en cycles per sample.
   - Response: exactly 16; adc_cs_n low exactly those cycles; bit_count reads 0..15 and is 0 after LATCH.
3. abort asserted during the 7th shift cycle of sample 2.
   - Response: IDLE next cycle, no further data_ready, no capture_done, sample_count=1, all strobes low.
4. Extra control_signal pulses during CONVERT and SHIFT.
   - Response: timing identical to scenario 1; the window is not restarted.
5. reset asserted during LATCH.
   - Response: next cycle all outputs at reset values, sample_count=0.
   - A following control_signal starts a fresh full window.
6. control_signal and abort simultaneous in IDLE.
   - Response: stays IDLE, data_logging=0.
   - A later lone control_signal starts normally.
